// File: rtl/demux_tdm_canais_pkg.sv
// Shared definitions for the TDM channel demultiplexer: default sizing and FSM encoding.
package tdm_defs;

  localparam int N_CANAIS_DEF = 4;
  localparam int W_DEF        = 1;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux_tdm_canais_if.sv
// Bundle of the serial input link and the per-channel outputs of the TDM demultiplexer.
interface demux_tdm_canais_if
  import tdm_defs::*;
#(
  parameter int N_CANAIS = N_CANAIS_DEF,
  parameter int W        = W_DEF
);
  localparam int SEL_W = $clog2(N_CANAIS);

  logic                    in_valid;
  logic [W-1:0]            in_data;
  logic                    in_sync;
  logic [N_CANAIS*W-1:0]   ch_data;
  logic [N_CANAIS-1:0]     ch_valid;
  logic                    frame_done;
  logic [SEL_W-1:0]        sel_atual;
  logic                    locked;
  logic                    sync_err;

  modport master (
    output in_valid, in_data, in_sync,
    input  ch_data, ch_valid, frame_done, sel_atual, locked, sync_err
  );

  modport slave (
    input  in_valid, in_data, in_sync,
    output ch_data, ch_valid, frame_done, sel_atual, locked, sync_err
  );

endinterface

// File: rtl/demux_tdm_canais_contador.sv
// Modulo-N slot counter with enable, synchronous load-to-1 for resync, and a last-slot flag.
module contador_slot #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr1,
  output logic [SEL_W-1:0] o_cnt,
  output logic             o_wrap
);

  logic [SEL_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == SEL_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr1) begin
      // A sync sample always lands in slot 0, so the next slot is 1.
      r_cnt <= SEL_W'(1);
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + SEL_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = w_wrap;

endmodule

// File: rtl/demux_tdm_canais.sv
// TDM receiver: locks a slot counter to the frame sync and routes each sample to its channel.
module demux_tdm_canais
  import tdm_defs::*;
#(
  parameter int N_CANAIS = N_CANAIS_DEF,
  parameter int W        = W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  demux_tdm_canais_if.slave   bus
);

  localparam int SEL_W = $clog2(N_CANAIS);

  state_t                r_state;
  state_t                w_state_next;
  logic [N_CANAIS*W-1:0] r_ch_data;
  logic [N_CANAIS-1:0]   r_ch_valid;
  logic                  r_frame_done;
  logic                  r_sync_err;

  logic                  w_wr_en;
  logic [SEL_W-1:0]      w_wr_ch;
  logic                  w_cnt_en;
  logic                  w_cnt_clr1;
  logic                  w_sync_err;
  logic                  w_frame_done;
  logic [SEL_W-1:0]      w_cnt;
  logic                  w_wrap;

  contador_slot #(
    .N     (N_CANAIS),
    .SEL_W (SEL_W)
  ) u_contador (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_cnt_en),
    .i_clr1 (w_cnt_clr1),
    .o_cnt  (w_cnt),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_wr_ch      = '0;
    w_cnt_en     = 1'b0;
    w_cnt_clr1   = 1'b0;
    w_sync_err   = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      ST_SEARCH: begin
        if (bus.in_valid && bus.in_sync) begin
          w_wr_en      = 1'b1;
          w_cnt_clr1   = 1'b1;
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (bus.in_valid) begin
          w_wr_en = 1'b1;
          if (bus.in_sync) begin
            // Misplaced sync resyncs in place; the aborted frame gets no frame_done.
            w_cnt_clr1 = 1'b1;
            w_sync_err = (w_cnt != '0);
          end else begin
            w_wr_ch      = w_cnt;
            w_cnt_en     = 1'b1;
            w_frame_done = w_wrap;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SEARCH;
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ch_valid   <= '0;
      r_frame_done <= w_frame_done;
      r_sync_err   <= w_sync_err;
      if (w_wr_en) begin
        r_ch_data[w_wr_ch*W +: W] <= bus.in_data;
        r_ch_valid[w_wr_ch]       <= 1'b1;
      end
    end
  end

  assign bus.ch_data    = r_ch_data;
  assign bus.ch_valid   = r_ch_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
  assign bus.locked     = (r_state == ST_LOCKED);
  assign bus.sel_atual  = w_cnt;

endmodule

// File: tb/tb_demux_tdm_canais.sv
// Directed scoreboard bench for demux_tdm_canais with N_CANAIS=4, W=1.
module tb_demux_tdm_canais;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] vld;
    logic       fd;
    logic       err;
    logic       lock;
    logic [1:0] sel;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t q[$];

  demux_tdm_canais_if #(.N_CANAIS(4), .W(1)) bus ();

  demux_tdm_canais #(
    .N_CANAIS (4),
    .W        (1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each clock edge that had stimulus issued is checked against its queued result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ch_data",    32'(bus.ch_data),    32'(e.data));
      chk("ch_valid",   32'(bus.ch_valid),   32'(e.vld));
      chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
      chk("sync_err",   32'(bus.sync_err),   32'(e.err));
      chk("locked",     32'(bus.locked),     32'(e.lock));
      chk("sel_atual",  32'(bus.sel_atual),  32'(e.sel));
    end
  end

  task automatic cyc(input logic r, input logic v, input logic s, input logic d,
                     input logic [3:0] ed, input logic [3:0] ev, input logic efd,
                     input logic eerr, input logic elock, input logic [1:0] esel);
    exp_t e;
    @(negedge clk);
    reset        = r;
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    e.data = ed; e.vld = ev; e.fd = efd; e.err = eerr; e.lock = elock; e.sel = esel;
    q.push_back(e);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(1, 1, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);

    // 1: no sync while searching -> everything dropped
    cyc(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);

    // 2: sync + 1,0,1,1
    cyc(0, 1, 1, 1, 4'b0001, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 0, 4'b0001, 4'b0010, 0, 0, 1, 2'd2);
    cyc(0, 1, 0, 1, 4'b0101, 4'b0100, 0, 0, 1, 2'd3);
    cyc(0, 1, 0, 1, 4'b1101, 4'b1000, 1, 0, 1, 2'd0);

    // 3: two back-to-back frames
    cyc(0, 1, 1, 0, 4'b1100, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 0, 4'b1100, 4'b0010, 0, 0, 1, 2'd2);
    cyc(0, 1, 0, 1, 4'b1100, 4'b0100, 0, 0, 1, 2'd3);
    cyc(0, 1, 0, 0, 4'b0100, 4'b1000, 1, 0, 1, 2'd0);
    cyc(0, 1, 1, 1, 4'b0101, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 1, 4'b0111, 4'b0010, 0, 0, 1, 2'd2);
    cyc(0, 1, 0, 0, 4'b0011, 4'b0100, 0, 0, 1, 2'd3);
    cyc(0, 1, 0, 1, 4'b1011, 4'b1000, 1, 0, 1, 2'd0);

    // 4: misplaced sync on slot 2 -> error, resync to channel 0
    cyc(0, 1, 1, 0, 4'b1010, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 0, 4'b1000, 4'b0010, 0, 0, 1, 2'd2);
    cyc(0, 1, 1, 1, 4'b1001, 4'b0001, 0, 1, 1, 2'd1);
    cyc(0, 1, 0, 1, 4'b1011, 4'b0010, 0, 0, 1, 2'd2);
    cyc(0, 1, 0, 1, 4'b1111, 4'b0100, 0, 0, 1, 2'd3);
    cyc(0, 1, 0, 0, 4'b0111, 4'b1000, 1, 0, 1, 2'd0);

    // 5: gaps in in_valid hold the counter
    cyc(0, 1, 1, 1, 4'b0111, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 0, 0, 0, 4'b0111, 4'b0000, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 0, 4'b0101, 4'b0010, 0, 0, 1, 2'd2);
    cyc(0, 0, 1, 1, 4'b0101, 4'b0000, 0, 0, 1, 2'd2);
    cyc(0, 1, 0, 0, 4'b0001, 4'b0100, 0, 0, 1, 2'd3);
    cyc(0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 1, 2'd3);
    cyc(0, 1, 0, 1, 4'b1001, 4'b1000, 1, 0, 1, 2'd0);
    cyc(0, 0, 0, 0, 4'b1001, 4'b0000, 0, 0, 1, 2'd0);

    // Missing sync at frame start is accepted as channel 0
    cyc(0, 1, 0, 1, 4'b1001, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 0, 4'b1001, 4'b0010, 0, 0, 1, 2'd2);

    // 6: reset on slot 2 clears everything; only a valid sync relocks
    cyc(1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    cyc(0, 1, 1, 1, 4'b0001, 4'b0001, 0, 0, 1, 2'd1);
    cyc(0, 1, 0, 1, 4'b0011, 4'b0010, 0, 0, 1, 2'd2);

    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected results still queued, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_tdm_canais.md
Name: demux_tdm_canais

Overview:
- Receiver end of the time-multiplexed channel link fed by the channel-select mux.
- Accepts one serial sample per valid cycle, tracks the current channel slot with a counter locked to a frame-sync marker, and routes each sample to a per-channel holding register.
- Per-channel strobes and a frame-complete pulse go to downstream logic.
- Detects and recovers from sync misalignment.

Parameters:
- N_CANAIS, 4, number of channels per frame; power of two, >= 2.
- W, 1, sample width in bits.
- SEL_W, $clog2(N_CANAIS), width of the slot counter (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_sync carry a sample this cycle.
- in_data  input  W  serial sample.
- in_sync  input  1  qualified by in_valid; marks the sample as channel 0 of a frame.
- ch_data  output  N_CANAIS*W  holding registers; channel k occupies bits [k*W +: W].
- ch_valid  output  N_CANAIS  one-cycle strobe; bit k = ch_data slice k updated this cycle.
- frame_done  output  1  one-cycle pulse when the channel N_CANAIS-1 sample is written.
- sel_atual  output  SEL_W  slot the next accepted sample goes to (valid only in LOCKED).
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on misplaced sync.

Behaviour:
Interface:
- One clock, clk.
- Reset is synchronous and active-high (reset); it is sampled only on the clk rising edge.

Reset:
- state=SEARCH; slot counter=0; ch_data=0; ch_valid=0; frame_done=0; sync_err=0; locked=0; sel_atual=0.
- Reset asserted mid-frame discards the partial frame; ch_data is cleared.

FSM, 2 states:
- SEARCH
  - in_valid without in_sync: sample dropped, no strobe.
  - in_valid with in_sync: sample written to channel 0, counter:=1, go to LOCKED.
- LOCKED
  - in_valid && !in_sync: write channel = counter; counter := counter+1, wrapping modulo N_CANAIS.
  - in_valid && in_sync && counter==0: normal frame start; write channel 0; counter:=1.
  - in_valid && in_sync && counter!=0: misalignment.
    - Pulse sync_err.
    - Write the sample to channel 0; counter:=1; stay LOCKED (resync, no SEARCH).
    - No frame_done for the aborted frame.
  - in_valid && !in_sync && counter==0 (missing sync at frame start): accepted as channel 0, no error (sync optional after lock).
- in_valid low: nothing changes; strobes low; counter holds.

Timing:
- All outputs registered; a sample accepted at edge t appears on ch_data/ch_valid after edge t (visible in cycle t+1).
- ch_valid is one-hot or zero.
- frame_done coincides with ch_valid[N_CANAIS-1].
- Untouched channel slices hold their last value.

Back-to-back:
- Full throughput, one sample per cycle; no backpressure.
- Counter wraps N_CANAIS-1 -> 0 in the same cycle frame_done asserts.

Decomposition:
- Shared package/header `tdm_defs`: localparams N_CANAIS_DEF=4, W_DEF=1; state encoding ST_SEARCH=1'b0, ST_LOCKED=1'b1.
- One sub-module, `contador_slot`: modulo-N counter with synchronous clear-to-1 (resync), enable and wrap flag. Used for the slot counter.
- Decode and write logic stays in the top module.

Test Plan:
All cases use N_CANAIS=4, W=1.
1. Reset then 3 valid samples without sync -> ch_valid stays 0, locked=0, ch_data=0.
2. Sync with data 1, then 0, 1, 1 on consecutive cycles -> ch_valid 0001, 0010, 0100, 1000; ch_data=4'b1101; frame_done high with 1000; sel_atual 1,2,3,0.
3. Two back-to-back frames (8 valid cycles, sync on 1st and 5th) -> frame_done pulses on cycles 4 and 8, sync_err=0.
4. Locked, sync on slot 2 -> sync_err pulses once; sample goes to channel 0; sel_atual=1 next; no frame_done for the broken frame.
5. in_valid gaps (1-0-1-0) during a frame -> counter holds across gaps; frame_done after the 4th valid sample only.
6. Reset asserted on slot 2 of a frame -> next cycle: locked=0, ch_data=0, ch_valid=0; subsequent non-sync samples are ignored until a sync arrives.
